// File: rtl/leg_mem_pkg.sv
// leg_mem_pkg: shared types and helpers for the dmem line-transfer controller
package leg_mem_pkg;
  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} line_state_t;
  localparam int BLOCKSIZE = 4;
  function automatic logic [63:0] line_base(input logic [63:0] addr, input int ow);
    return addr & ~((64'd1 << ow) - 64'd1);
  endfunction
endpackage

// File: rtl/line_beat_counter.sv
// line_beat_counter: word index within the line, flags the final accepted beat
module line_beat_counter #(
  parameter int BLOCKSIZE = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         inc,
  output logic [$clog2(BLOCKSIZE)-1:0] cnt,
  output logic                         last
);
  localparam int CW = $clog2(BLOCKSIZE);
  logic [CW-1:0] cnt_q, cnt_d;
  // advance on each accepted beat, wrapping naturally at the end of the line
  always_comb cnt_d = clear ? '0 : inc ? cnt_q + 1'b1 : cnt_q;
  // beat index register
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt  = cnt_q;
  assign last = inc && cnt_q == CW'(BLOCKSIZE - 1);
endmodule

// File: rtl/dmem_line_ctrl.sv
// dmem_line_ctrl: turns cache-line fill/writeback requests into word bursts on dmem
module dmem_line_ctrl #(
  parameter int BLOCKSIZE = leg_mem_pkg::BLOCKSIZE,
  parameter int AW        = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         Fill,
  input  logic                         Writeback,
  input  logic [AW-1:0]                FillAddr,
  input  logic [AW-1:0]                WBAddr,
  input  logic [32*BLOCKSIZE-1:0]      WBData,
  output logic                         Busy,
  output logic                         Done,
  output logic                         FillWordEn,
  output logic [$clog2(BLOCKSIZE)-1:0] FillWordIdx,
  output logic [31:0]                  FillWordData,
  output logic                         HSEL,
  output logic                         re,
  output logic                         we,
  output logic [AW-1:0]                a,
  output logic [31:0]                  wd,
  input  logic [31:0]                  rd,
  input  logic                         Valid
);
  import leg_mem_pkg::*;
  localparam int CW = $clog2(BLOCKSIZE);
  localparam int OW = CW + 2;
  line_state_t               state_q, state_d;
  logic [AW-1:0]             wb_addr_q, fill_addr_q, line_addr;
  logic [32*BLOCKSIZE-1:0]   wb_data_q;
  logic                      fill_pend_q;
  logic                      fill_en_q;
  logic [CW-1:0]             fill_idx_q;
  logic [31:0]               fill_word_q;
  logic [CW-1:0]             cnt;
  logic                      last;
  logic                      beat;
  logic                      accept;
  assign accept = state_q == IDLE && (Writeback || Fill);
  assign beat   = Valid && (state_q == WB || state_q == FILL);
  line_beat_counter #(.BLOCKSIZE(BLOCKSIZE)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == IDLE),
    .inc   (beat),
    .cnt   (cnt),
    .last  (last)
  );
  // writeback always precedes a fill requested in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = Writeback ? WB : Fill ? FILL : IDLE;
      WB:      state_d = last ? (fill_pend_q ? FILL : DONE) : WB;
      FILL:    state_d = last ? DONE : FILL;
      default: state_d = IDLE;
    endcase
  end
  // transfer state
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  // capture the request once when it is accepted; later requests are ignored until idle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      fill_addr_q <= '0;
      fill_pend_q <= 1'b0;
    end else begin
      if (accept) fill_addr_q <= FillAddr;
      if (accept && Writeback) begin
        wb_addr_q   <= WBAddr;
        wb_data_q   <= WBData;
        fill_pend_q <= Fill;
      end
    end
  // fill words are registered from rd and presented the cycle after their beat
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fill_en_q   <= 1'b0;
      fill_idx_q  <= '0;
      fill_word_q <= '0;
    end else begin
      fill_en_q <= state_q == FILL && Valid;
      if (state_q == FILL && Valid) begin
        fill_idx_q  <= cnt;
        fill_word_q <= rd;
      end
    end
  assign Busy         = state_q != IDLE;
  assign Done         = state_q == DONE;
  assign HSEL         = state_q == WB || state_q == FILL;
  assign we           = state_q == WB;
  assign re           = state_q == FILL;
  assign line_addr    = we ? wb_addr_q : fill_addr_q;
  assign a            = HSEL ? AW'(line_base(64'(line_addr), OW)) | AW'({cnt, 2'b00}) : '0;
  assign wd           = we ? wb_data_q[{cnt, 5'b00000} +: 32] : '0;
  assign FillWordEn   = fill_en_q;
  assign FillWordIdx  = fill_idx_q;
  assign FillWordData = fill_word_q;
endmodule
